ccr_save_stack: RTL and testbench
=================================

# ccr_save_stack

Interrupt-context flag save/restore stack that sits directly upstream of the status register's `savedStatus` input. On interrupt entry it captures the live CCR (`1 | carry | negative | zero`) into a LIFO. On return-from-interrupt it pops the most recent entry and presents it with a one-cycle restore strobe, which the status register consumes as an `updateStatus` with carry-control `2'b10`. Nested interrupts up to `DEPTH` levels are supported; overflow and underflow are flagged, never silently corrupted.

## Interface
- `DEPTH`, 4: number of nested saved CCR entries; power of two, ≥2.
- `FLAG_W`, 4: CCR width; fixed at 4 for this processor.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-high; one clock, clears all state.
- `hold` in 1: pipeline stall; when 1, no state changes and `restoreValid` is forced to 0.
- `push` in 1: interrupt entry; save `liveFlags` this cycle.
- `pop` in 1: RTI; restore the top entry.
- `liveFlags` in FLAG_W: current CCR (`StatusFlags` of the status register).
- `savedStatus` out FLAG_W: restored CCR value; feeds the status register `savedStatus`.
- `restoreValid` out 1: one-cycle strobe; `savedStatus` is valid to load.
- `depth` out $clog2(DEPTH)+1: current entry count.
- `empty` out 1: `depth == 0`.
- `full` out 1: `depth == DEPTH`.
- `overflowErr` out 1: sticky; a push was dropped.
- `underflowErr` out 1: sticky; a pop was ignored.

## Operation
- Reset values: `savedStatus = 4'b1000` (CCR reset value), `restoreValid = 0`, `depth = 0`, `empty = 1`, `full = 0`, both error flags 0. Storage contents are don't-care.
- Cases below apply only when `hold = 0` and `reset = 0`. With `hold = 1`, all registers keep their values and `restoreValid = 0`.
- Push only:
  - Not full: write `liveFlags` at index `depth`, then `depth + 1`.
  - Full: drop the push; `depth` unchanged; set `overflowErr`.
- Pop only:
  - Not empty: register `savedStatus <= mem[depth-1]` and `restoreValid <= 1`, then `depth - 1`.
  - Empty: `restoreValid <= 0`, `savedStatus` unchanged; set `underflowErr`.
- Push and pop together (interrupt taken in the RTI cycle):
  - Non-empty: pop first, then push. `savedStatus <= old top`, `restoreValid <= 1`, top slot overwritten with `liveFlags`, `depth` unchanged. This is legal even when full.
  - Empty: pop is ignored (`underflowErr` set); push proceeds normally.
- Neither asserted: `restoreValid <= 0`; everything else holds.
- `restoreValid` is never high for two consecutive cycles unless pop is asserted on consecutive cycles.
- Error flags are cleared only by `reset`.
- `empty`, `full` and `depth` are registered-state derived, with no combinational path from `push`/`pop`.
- The block has no explicit FSM beyond the depth counter. The counter behaves as a saturating up/down counter over 0..DEPTH, with the rules above at both ends.

## Timing
- Push in cycle N: the entry is stored at the N edge; `depth` updates in N+1.
- Pop in cycle N: `savedStatus` and `restoreValid` are valid in N+1 (registered, 1-cycle latency). The status register samples them combinationally in N+1.
- Push in N, pop in N+1: `savedStatus` in N+2 equals `liveFlags` sampled at N. Storage is written at the edge, so no bypass is needed.
- `reset` asserted mid-operation: everything is cleared at the next edge; any in-flight `restoreValid` drops in the following cycle.
- `reset` has priority over `hold`, and `hold` has priority over `push`/`pop`.

## Structure
- Shared package `ccr_pkg`:
  - `CCR_RESET = 4'b1000`
  - `FLAG_W = 4`
  - bit indices `CCR_Z = 0`, `CCR_N = 1`, `CCR_C = 2`, `CCR_ONE = 3`
  - carry-control encoding constants `CC_LOAD = 2'b00`, `CC_CLRC = 2'b01`, `CC_RESTORE = 2'b10`, `CC_SETC = 2'b11`
- Sub-module `ccr_lifo`: a DEPTH×FLAG_W register array with a single write port and a combinational top read (`mem[depth-1]`). The top-level module owns the depth counter, error flags and output registers.

## Test plan
- Reset, then three pushes of `4'b1001`, `4'b1010`, `4'b1100`, then three pops: `savedStatus` reads 1100, 1010, 1001 on consecutive cycles with `restoreValid = 1`; `depth` returns to 0 and `empty = 1`.
- With DEPTH=4: five pushes leave `full = 1` and `depth = 4` with `overflowErr = 1`; four pops return the first four values in reverse order; the fifth value never appears.
- Pop on empty: `restoreValid` stays 0, `savedStatus` stays `4'b1000`, `underflowErr = 1` and remains set after further valid traffic.
- Push `4'b1001`, then push and pop together with `liveFlags = 4'b1110`: `savedStatus = 1001` with `restoreValid = 1` and `depth = 1`; a subsequent pop returns 1110.
- Push followed by pop with `hold = 1` during the pop cycle: no restore occurs until `hold` drops; pop then produces 1-cycle-latency `restoreValid`.
- Reset asserted the cycle after a pop: `restoreValid` is low after the reset edge, `depth = 0`, and errors are cleared.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared condition-code register definitions: reset value, bit positions and
// the carry-control encodings understood by the status register.
package ccr_pkg;

  localparam int FLAG_W = 4;

  localparam logic [FLAG_W-1:0] CCR_RESET = 4'b1000;

  // Bit positions inside the CCR word {1, C, N, Z}.
  localparam int CCR_Z   = 0;
  localparam int CCR_N   = 1;
  localparam int CCR_C   = 2;
  localparam int CCR_ONE = 3;

  // Carry-control field of the status register update.
  typedef enum logic [1:0] {
    CC_LOAD    = 2'b00,
    CC_CLRC    = 2'b01,
    CC_RESTORE = 2'b10,
    CC_SETC    = 2'b11
  } carry_ctrl_e;

endpackage : ccr_pkg

// File: rtl/ccr_lifo.sv
// Storage for saved CCR words: one write port and a combinational read of
// the current top entry (mem[depth-1]). Depth tracking lives in the parent.
module ccr_lifo
  import ccr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FLAG_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH):0]   depth,
  output logic [W-1:0]             top
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] top_idx;

  // With depth == 0 the index wraps; the parent never uses top when empty.
  assign top_idx = AW'(depth - DW'(1));
  assign top     = mem[top_idx];

  // Single write port into the entry array.
  // NOTE: the array has no reset on purpose; contents are only read below the
  // depth pointer, so clearing it would just add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule : ccr_lifo

// File: rtl/ccr_save_stack.sv
// Interrupt-context CCR save/restore stack. Push captures the live CCR on
// interrupt entry; pop (RTI) returns the newest entry with a one-cycle
// restoreValid strobe feeding the status register's savedStatus input.
module ccr_save_stack #(
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   push,
  input  logic                   pop,
  input  logic [FLAG_W-1:0]      liveFlags,
  output logic [FLAG_W-1:0]      savedStatus,
  output logic                   restoreValid,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   empty,
  output logic                   full,
  output logic                   overflowErr,
  output logic                   underflowErr
);

  import ccr_pkg::CCR_RESET;

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [DW-1:0]     depth_q, depth_nxt;
  logic [FLAG_W-1:0] saved_q, saved_nxt;
  logic              rv_q, rv_nxt;
  logic              ovf_q, ovf_nxt;
  logic              unf_q, unf_nxt;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     top_idx;
  logic [FLAG_W-1:0] top;
  logic              is_empty, is_full;

  // Status flags come only from registered depth, never from push/pop.
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DW'(DEPTH));
  assign top_idx  = AW'(depth_q - DW'(1));

  // The write is suppressed during reset so a stray push cannot land.
  ccr_lifo #(
    .DEPTH (DEPTH),
    .W     (FLAG_W)
  ) u_lifo (
    .clk   (clk),
    .we    (we && !reset),
    .waddr (waddr),
    .wdata (liveFlags),
    .depth (depth_q),
    .top   (top)
  );

  // Next-state decode: pop resolves first, then push against the result.
  // NOTE: every always_comb output gets a default up front so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    depth_nxt = depth_q;
    saved_nxt = saved_q;
    rv_nxt    = 1'b0;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;
    we        = 1'b0;
    waddr     = depth_q[AW-1:0];

    if (!hold) begin
      if (pop) begin
        if (!is_empty) begin
          saved_nxt = top;
          rv_nxt    = 1'b1;
        end else begin
          unf_nxt = 1'b1;
        end
      end

      if (push) begin
        if (pop && !is_empty) begin
          // Pop-then-push: the vacated top slot takes the new entry.
          we    = 1'b1;
          waddr = top_idx;
        end else if (!is_full) begin
          we        = 1'b1;
          waddr     = depth_q[AW-1:0];
          depth_nxt = depth_q + DW'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
      end else if (pop && !is_empty) begin
        depth_nxt = depth_q - DW'(1);
      end
    end
  end

  // State registers with synchronous reset; hold is folded into the decode.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      saved_q <= CCR_RESET;
      rv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_nxt;
      saved_q <= saved_nxt;
      rv_q    <= rv_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign savedStatus  = saved_q;
  assign restoreValid = rv_q;
  assign depth        = depth_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign overflowErr  = ovf_q;
  assign underflowErr = unf_q;

endmodule : ccr_save_stack

// File: tb/tb_ccr_save_stack.sv
// Directed bench for ccr_save_stack (DEPTH=4): LIFO order, overflow,
// underflow, simultaneous push/pop, hold and mid-stream reset.
module tb_ccr_save_stack;

  logic       clk = 1'b0;
  logic       reset, hold, push, pop;
  logic [3:0] liveFlags;
  logic [3:0] savedStatus;
  logic       restoreValid;
  logic [2:0] depth;
  logic       empty, full, overflowErr, underflowErr;

  int checks = 0;
  int passed = 0;

  ccr_save_stack #(
    .DEPTH  (4),
    .FLAG_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .push         (push),
    .pop          (pop),
    .liveFlags    (liveFlags),
    .savedStatus  (savedStatus),
    .restoreValid (restoreValid),
    .depth        (depth),
    .empty        (empty),
    .full         (full),
    .overflowErr  (overflowErr),
    .underflowErr (underflowErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 ns after the edge.
  task automatic step(input logic rs, input logic hd, input logic ps,
                      input logic pp, input logic [3:0] lf);
    reset = rs; hold = hd; push = ps; pop = pp; liveFlags = lf;
    @(posedge clk);
    #1;
    reset = 1'b0; hold = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ss, input logic rv,
                           input logic [2:0] d);
    check({tag, ".saved"}, {4'b0, savedStatus}, {4'b0, ss});
    check({tag, ".rv"},    {7'b0, restoreValid}, {7'b0, rv});
    check({tag, ".depth"}, {5'b0, depth}, {5'b0, d});
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f,
                             input logic ov, input logic un);
    check({tag, ".empty"}, {7'b0, empty}, {7'b0, e});
    check({tag, ".full"},  {7'b0, full},  {7'b0, f});
    check({tag, ".ovf"},   {7'b0, overflowErr},  {7'b0, ov});
    check({tag, ".unf"},   {7'b0, underflowErr}, {7'b0, un});
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0; push = 1'b0; pop = 1'b0; liveFlags = 4'b0;
    #2;

    // Reset state
    step(1, 0, 0, 0, 4'b0);
    check_out("rst", 4'b1000, 0, 3'd0);
    check_flags("rst", 1, 0, 0, 0);

    // Three pushes, three pops in LIFO order
    step(0, 0, 1, 0, 4'b1001);
    check_out("p1", 4'b1000, 0, 3'd1);
    step(0, 0, 1, 0, 4'b1010);
    step(0, 0, 1, 0, 4'b1100);
    check_out("p3", 4'b1000, 0, 3'd3);
    step(0, 0, 0, 1, 4'b0);
    check_out("pop1", 4'b1100, 1, 3'd2);
    step(0, 0, 0, 1, 4'b0);
    check_out("pop2", 4'b1010, 1, 3'd1);
    step(0, 0, 0, 1, 4'b0);
    check_out("pop3", 4'b1001, 1, 3'd0);
    check_flags("pop3", 1, 0, 0, 0);
    step(0, 0, 0, 0, 4'b0);
    check_out("idle", 4'b1001, 0, 3'd0);

    // Overflow: five pushes into a four-deep stack
    step(0, 0, 1, 0, 4'b1001);
    step(0, 0, 1, 0, 4'b1011);
    step(0, 0, 1, 0, 4'b1101);
    step(0, 0, 1, 0, 4'b1111);
    check_out("fill", 4'b1001, 0, 3'd4);
    check_flags("fill", 0, 1, 0, 0);
    step(0, 0, 1, 0, 4'b1110);
    check_out("ovf", 4'b1001, 0, 3'd4);
    check_flags("ovf", 0, 1, 1, 0);
    step(0, 0, 0, 1, 4'b0);
    check_out("opop1", 4'b1111, 1, 3'd3);
    step(0, 0, 0, 1, 4'b0);
    check_out("opop2", 4'b1101, 1, 3'd2);
    step(0, 0, 0, 1, 4'b0);
    check_out("opop3", 4'b1011, 1, 3'd1);
    step(0, 0, 0, 1, 4'b0);
    check_out("opop4", 4'b1001, 1, 3'd0);
    check_flags("opop4", 1, 0, 1, 0);

    // Underflow on empty, then sticky through valid traffic
    step(1, 0, 0, 0, 4'b0);
    step(0, 0, 0, 1, 4'b0);
    check_out("unf", 4'b1000, 0, 3'd0);
    check_flags("unf", 1, 0, 0, 1);
    step(0, 0, 1, 0, 4'b1011);
    step(0, 0, 0, 1, 4'b0);
    check_out("unf_pop", 4'b1011, 1, 3'd0);
    check_flags("unf_pop", 1, 0, 0, 1);

    // Push then simultaneous push+pop
    step(1, 0, 0, 0, 4'b0);
    step(0, 0, 1, 0, 4'b1001);
    step(0, 0, 1, 1, 4'b1110);
    check_out("pp", 4'b1001, 1, 3'd1);
    step(0, 0, 0, 1, 4'b0);
    check_out("pp_pop", 4'b1110, 1, 3'd0);

    // Hold suppresses a pop and a push
    step(0, 0, 1, 0, 4'b1101);
    step(0, 1, 0, 1, 4'b0);
    check_out("hold_pop", 4'b1110, 0, 3'd1);
    step(0, 1, 1, 0, 4'b0111);
    check_out("hold_push", 4'b1110, 0, 3'd1);
    step(0, 0, 0, 1, 4'b0);
    check_out("unhold", 4'b1101, 1, 3'd0);

    // Push+pop on empty: pop ignored, push proceeds
    step(0, 0, 1, 1, 4'b0111);
    check_out("pp_empty", 4'b1101, 0, 3'd1);
    check_flags("pp_empty", 0, 0, 0, 1);
    step(0, 0, 0, 1, 4'b0);
    check_out("pp_empty_pop", 4'b0111, 1, 3'd0);

    // Full + push+pop is legal: top replaced, depth stays 4
    step(1, 0, 0, 0, 4'b0);
    step(0, 0, 1, 0, 4'b1000);
    step(0, 0, 1, 0, 4'b1001);
    step(0, 0, 1, 0, 4'b1010);
    step(0, 0, 1, 0, 4'b1011);
    step(0, 0, 1, 1, 4'b1100);
    check_out("full_pp", 4'b1011, 1, 3'd4);
    check_flags("full_pp", 0, 1, 0, 0);
    step(0, 0, 0, 1, 4'b0);
    check_out("full_pp_pop", 4'b1100, 1, 3'd3);

    // Reset the cycle after a pop, with an error pending
    step(1, 0, 0, 0, 4'b0);
    step(0, 0, 0, 1, 4'b0);
    step(0, 0, 1, 0, 4'b1010);
    step(0, 0, 1, 0, 4'b1100);
    step(0, 0, 0, 1, 4'b0);
    check_out("pre_rst", 4'b1100, 1, 3'd1);
    step(1, 1, 1, 0, 4'b0101);
    check_out("mid_rst", 4'b1000, 0, 3'd0);
    check_flags("mid_rst", 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_ccr_save_stack
